fa_serial_ctrl: RTL

//  Bit-serial add/subtract controller: sequences one 1-bit full-adder cell over W cycles
//  to produce a W-bit sum, with a carry flip-flop between bit steps.

---
 rtl/fa_pkg.sv | 13 +
 rtl/fa_bit.sv | 13 +
 rtl/fa_serial_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/fa_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package fa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder cell, reused every bit step by the serial controller.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_serial_ctrl.sv
// Bit-serial add/subtract: one full-adder cell stepped over W cycles, LSB first,
// with valid/ready handshakes on the operand and result sides.
module fa_serial_ctrl
  import fa_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned CW = $clog2(W);

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sh_a;
  logic [W-1:0]  sh_b;
  logic [W-1:0]  sh_s;
  logic          carry;
  logic          fa_s;
  logic          fa_c;
  logic          is_idle;
  logic          is_run;
  logic          is_done;
  logic          last;

  // The unused encoding 2'd3 behaves as IDLE.
  assign is_run  = (state == RUN);
  assign is_done = (state == DONE);
  assign is_idle = !is_run && !is_done;
  assign last    = (cnt == CW'(W - 1));

  fa_bit u_fa_bit (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d = state;
    case (state)
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = in_valid ? RUN : IDLE;
    endcase
  end

  // Subtraction loads ~b with carry-in 1, so the same cell computes a + ~b + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      sh_a  <= '0;
      sh_b  <= '0;
      sh_s  <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      if (is_idle && in_valid) begin
        sh_a  <= a;
        sh_b  <= (sub == OP_ADD) ? b : ~b;
        carry <= (sub == OP_SUB);
        cnt   <= '0;
      end else if (is_run) begin
        sh_s  <= {fa_s, sh_s[W-1:1]};
        sh_a  <= {1'b0, sh_a[W-1:1]};
        sh_b  <= {1'b0, sh_b[W-1:1]};
        carry <= fa_c;
        cnt   <= last ? '0 : cnt + CW'(1);
        if (last) begin
          cout <= fa_c;
          ovf  <= carry ^ fa_c;
        end
      end
    end
  end

  assign in_ready  = is_idle;
  assign out_valid = is_done;
  assign sum       = sh_s;

endmodule
